multicycle_controller: RTL

Main finite-state controller for the multicycle RV32I core. It sequences one shared memory port, the register file, the ALU and the PC/IR/ALUOut registers over several cycles per instruction. It supports lw, sw, R-type, I-type ALU, beq and jal. It stalls on a memory ready handshake, halts on unsupported opcodes and counts retired instructions.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// Latency: none, plain wires; the controller drives the o_* signals combinationally.
// Backpressure: i_memReady from the shared memory stalls FETCH, MEMREAD and MEMWRITE.
//
// Signals:
//   i_opcode, i_zero, i_memReady        : datapath/memory status into the controller
//   o_pcWrite .. o_aluOp                : datapath enables and mux selects
//   o_halted, o_state, o_retired        : status/debug outputs
interface multicycle_controller_if #(
    parameter int RETIRED_W = 32
);
    logic [6:0]           i_opcode;
    logic                 i_zero;
    logic                 i_memReady;
    logic                 o_pcWrite;
    logic                 o_adrSrc;
    logic                 o_irWrite;
    logic                 o_memWrite;
    logic                 o_regWrite;
    logic [1:0]           o_resultSrc;
    logic [1:0]           o_aluSrcA;
    logic [1:0]           o_aluSrcB;
    logic [1:0]           o_aluOp;
    logic                 o_halted;
    logic [3:0]           o_state;
    logic [RETIRED_W-1:0] o_retired;

    // Controller side.
    modport slave (
        input  i_opcode, i_zero, i_memReady,
        output o_pcWrite, o_adrSrc, o_irWrite, o_memWrite, o_regWrite,
               o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluOp,
               o_halted, o_state, o_retired
    );

    // Datapath / stimulus side.
    modport master (
        output i_opcode, i_zero, i_memReady,
        input  o_pcWrite, o_adrSrc, o_irWrite, o_memWrite, o_regWrite,
               o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluOp,
               o_halted, o_state, o_retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core (lw, sw, R-type, I-type, beq, jal); halts on other opcodes.
// Latency: 3-5 cycles per instruction with memory ready; control outputs are combinational from state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their state while i_memReady is low.
//
// Ports:
//   i_clk, i_srst : clock and synchronous active-high reset
//   bus (slave)   : opcode/zero/memReady in; enables, selects, halted, state and retired count out
module multicycle_controller #(
    parameter int RETIRED_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    multicycle_controller_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e               state_q, state_d;
    logic [RETIRED_W-1:0] retired_q, retired_d;

    logic       pc_write, ir_write, mem_write, reg_write, adr_src, halted, retire;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        halted     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR captures the fetched word.
                result_src = 2'b10;
                alu_src_b  = 2'b10;
                pc_write   = bus.i_memReady;
                ir_write   = bus.i_memReady;
                if (bus.i_memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target OldPC+imm is precomputed into ALUOut here.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // Opcode bit 5 is the only difference between lw and sw.
                state_d   = bus.i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.i_memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe is held for the whole stall so the memory sees a stable request.
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.i_memReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BEQ: begin
                // ALUOut already holds the target from DECODE; subtract compares rs1/rs2.
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = bus.i_zero;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_JAL: begin
                // PC <- target from ALUOut while the ALU forms the link OldPC+4 for ALUWB.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase

        if (retire) retired_d = retired_q + RETIRED_W'(1);
    end

    // Enables are suppressed for the whole reset cycle, even mid-instruction.
    assign bus.o_pcWrite   = pc_write  & ~i_srst;
    assign bus.o_irWrite   = ir_write  & ~i_srst;
    assign bus.o_memWrite  = mem_write & ~i_srst;
    assign bus.o_regWrite  = reg_write & ~i_srst;
    assign bus.o_adrSrc    = adr_src;
    assign bus.o_resultSrc = result_src;
    assign bus.o_aluSrcA   = alu_src_a;
    assign bus.o_aluSrcB   = alu_src_b;
    assign bus.o_aluOp     = alu_op;
    assign bus.o_halted    = halted;
    assign bus.o_state     = state_q;
    assign bus.o_retired   = retired_q;

endmodule
